// File: rtl/twi_target.sv
// twi_target: I2C target exposing an 8-byte register bank plus a status byte.
// Filtered SCL/SDA, START/STOP detection, auto-incrementing pointer, open-drain SDA.
module twi_target #(
    parameter logic [6:0]  SLV_ADDR = 7'h38,
    parameter int unsigned FILT     = 3
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        TWI_SCL_I,
    input  logic        TWI_SDA_I,
    output logic        TWI_SDA_OEN,
    input  logic [7:0]  STATUS_IN,
    output logic [63:0] REG_FLAT,
    output logic        WR_STB,
    output logic [7:0]  WR_ADDR,
    output logic        BUSY
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX,
        S_RX_ACK, S_TX, S_TX_ACK, S_WAIT
    } state_t;

    localparam logic [3:0] FLIM = 4'(FILT - 1);

    state_t      state, state_n;
    logic        scl_s1, scl_s2, sda_s1, sda_s2;
    logic [3:0]  scl_cnt, sda_cnt;
    logic        scl_f, sda_f, scl_d, sda_d;
    logic        rise, fall, start, stop;
    logic [7:0]  sh, sh_n, ptr, ptr_n;
    logic [7:0]  tx_byte, waddr_n;
    logic [2:0]  bcnt, bcnt_n;
    logic        full, full_n;
    logic        first, first_n;
    logic        rw, rw_n;
    logic        oen, oen_n;
    logic        stb_n, busy_n;
    logic [63:0] reg_n;

    // two-stage synchronizers on both pad inputs
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            {scl_s1, scl_s2} <= 2'b11;
            {sda_s1, sda_s2} <= 2'b11;
        end else begin
            scl_s1 <= TWI_SCL_I;
            scl_s2 <= scl_s1;
            sda_s1 <= TWI_SDA_I;
            sda_s2 <= sda_s1;
        end
    end

    // a filtered line follows only after FILT consecutive differing samples
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            scl_cnt <= '0;
            sda_cnt <= '0;
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
        end else begin
            if (scl_s2 == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FLIM) begin
                scl_f   <= scl_s2;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
            if (sda_s2 == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FLIM) begin
                sda_f   <= sda_s2;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
        end
    end

    // one-cycle delayed filtered lines for edge detection
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign rise  = scl_f & ~scl_d;
    assign fall  = ~scl_f & scl_d;
    assign start = scl_f & sda_d & ~sda_f;
    assign stop  = scl_f & ~sda_d & sda_f;

    assign tx_byte = (ptr < 8'd8)  ? REG_FLAT[{ptr[2:0], 3'b000} +: 8] :
                     (ptr == 8'd8) ? STATUS_IN : 8'h00;

    assign TWI_SDA_OEN = oen;

    // state and datapath registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state    <= S_IDLE;
            sh       <= '0;
            bcnt     <= '0;
            full     <= 1'b0;
            ptr      <= '0;
            first    <= 1'b0;
            rw       <= 1'b0;
            oen      <= 1'b1;
            REG_FLAT <= '0;
            WR_STB   <= 1'b0;
            WR_ADDR  <= '0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            bcnt     <= bcnt_n;
            full     <= full_n;
            ptr      <= ptr_n;
            first    <= first_n;
            rw       <= rw_n;
            oen      <= oen_n;
            REG_FLAT <= reg_n;
            WR_STB   <= stb_n;
            WR_ADDR  <= waddr_n;
            BUSY     <= busy_n;
        end
    end

    // next state; bus events override bit handling
    always_comb begin
        state_n = state;
        sh_n    = sh;
        bcnt_n  = bcnt;
        full_n  = full;
        ptr_n   = ptr;
        first_n = first;
        rw_n    = rw;
        oen_n   = oen;
        reg_n   = REG_FLAT;
        stb_n   = 1'b0;
        waddr_n = WR_ADDR;
        busy_n  = BUSY;
        if (start) begin
            state_n = S_ADDR;
            bcnt_n  = '0;
            full_n  = 1'b0;
            oen_n   = 1'b1;
        end else if (stop) begin
            state_n = S_IDLE;
            full_n  = 1'b0;
            oen_n   = 1'b1;
            busy_n  = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_RX: begin
                    if (rise) begin
                        sh_n   = {sh[6:0], sda_f};
                        bcnt_n = bcnt + 3'd1;
                        if (bcnt == 3'd7) full_n = 1'b1;
                    end else if (fall && full) begin
                        full_n = 1'b0;
                        if (state == S_ADDR) begin
                            if (sh[7:1] == SLV_ADDR) begin
                                state_n = S_ADDR_ACK;
                                oen_n   = 1'b0;
                                rw_n    = sh[0];
                                busy_n  = 1'b1;
                            end else begin
                                state_n = S_WAIT;
                                busy_n  = 1'b0;
                            end
                        end else begin
                            state_n = S_RX_ACK;
                            oen_n   = 1'b0;
                            if (first) begin
                                ptr_n   = sh;
                                first_n = 1'b0;
                            end else begin
                                if (ptr < 8'd8)
                                    reg_n[{ptr[2:0], 3'b000} +: 8] = sh;
                                stb_n   = 1'b1;
                                waddr_n = ptr;
                                ptr_n   = ptr + 8'd1;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (fall) begin
                        bcnt_n = '0;
                        full_n = 1'b0;
                        if (rw) begin
                            sh_n    = tx_byte;
                            oen_n   = tx_byte[7];
                            ptr_n   = ptr + 8'd1;
                            state_n = S_TX;
                        end else begin
                            oen_n   = 1'b1;
                            first_n = 1'b1;
                            state_n = S_RX;
                        end
                    end
                end
                S_RX_ACK: begin
                    if (fall) begin
                        oen_n   = 1'b1;
                        bcnt_n  = '0;
                        state_n = S_RX;
                    end
                end
                S_TX: begin
                    if (rise) begin
                        bcnt_n = bcnt + 3'd1;
                        if (bcnt == 3'd7) full_n = 1'b1;
                    end else if (fall) begin
                        if (full) begin
                            full_n  = 1'b0;
                            oen_n   = 1'b1;
                            state_n = S_TX_ACK;
                        end else begin
                            sh_n  = {sh[6:0], 1'b0};
                            oen_n = sh[6];
                        end
                    end
                end
                S_TX_ACK: begin
                    if (rise) begin
                        if (sda_f) begin
                            state_n = S_WAIT;
                            busy_n  = 1'b0;
                        end else begin
                            full_n = 1'b1;
                        end
                    end else if (fall && full) begin
                        full_n  = 1'b0;
                        bcnt_n  = '0;
                        sh_n    = tx_byte;
                        oen_n   = tx_byte[7];
                        ptr_n   = ptr + 8'd1;
                        state_n = S_TX;
                    end
                end
                S_WAIT: begin
                    oen_n  = 1'b1;
                    busy_n = 1'b0;
                end
                default: begin
                    oen_n = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_twi_target.sv
// tb_twi_target: bus-level I2C master driving twi_target, checked
// against a transaction-level model of the register bank and pointer.
module tb_twi_target;
    localparam int Q = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_scl, m_sda;
    logic        sda_bus, oen;
    logic [7:0]  status;
    logic [63:0] reg_flat;
    logic        wr_stb, busy;
    logic [7:0]  wr_addr;

    int tests = 0;
    int fails = 0;

    logic [7:0] mregs [8];
    logic [7:0] mptr;
    logic       mbusy;
    logic       chk;
    logic       glitch;
    logic       prev_stb;
    logic [7:0] exp_wq [$];
    logic [7:0] got_wq [$];
    logic [7:0] wbuf [8];
    logic [7:0] rbuf [8];

    always #5 clk = ~clk;

    assign sda_bus = m_sda & oen;

    twi_target #(.SLV_ADDR(7'h38), .FILT(3)) dut (
        .CLK_I(clk),
        .RST_I(rst),
        .TWI_SCL_I(m_scl),
        .TWI_SDA_I(sda_bus),
        .TWI_SDA_OEN(oen),
        .STATUS_IN(status),
        .REG_FLAT(reg_flat),
        .WR_STB(wr_stb),
        .WR_ADDR(wr_addr),
        .BUSY(busy)
    );

    task automatic chk_eq(input string nm, input logic [63:0] got,
                          input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] mflat();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[8*i +: 8] = mregs[i];
        return f;
    endfunction

    function automatic logic [7:0] mdata(input logic [7:0] p);
        if (p < 8) return mregs[p[2:0]];
        if (p == 8) return status;
        return 8'h00;
    endfunction

    function automatic logic [7:0] qat(input int i);
        if (i < got_wq.size()) return got_wq[i];
        return 8'hxx;
    endfunction

    // per-cycle comparison of bank and BUSY while SCL is high
    always @(negedge clk) begin
        if (chk) begin
            chk_eq("reg_flat", reg_flat, mflat());
            chk_eq("busy", 64'(busy), 64'(mbusy));
        end
    end

    // collect write strobes, each must be one cycle wide
    always @(negedge clk) begin
        if (wr_stb) begin
            got_wq.push_back(wr_addr);
            chk_eq("wr_stb_width", 64'(prev_stb), 64'd0);
        end
        prev_stb <= wr_stb;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_x(input logic b, output logic r);
        cyc(Q);
        m_sda = b;
        if (glitch) begin
            cyc(4);
            m_scl = 1'b1;
            cyc(1);
            m_scl = 1'b0;
            glitch = 1'b0;
            cyc(Q - 5);
        end else begin
            cyc(Q);
        end
        m_scl = 1'b1;
        cyc(12);
        r = sda_bus;
        chk = 1'b1;
        cyc(18);
        chk = 1'b0;
        cyc(2);
        m_scl = 1'b0;
    endtask

    task automatic send8(input logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(d[i], r);
    endtask

    task automatic recv8(output logic [7:0] d);
        logic r;
        for (int i = 0; i < 8; i++) begin
            bit_x(1'b1, r);
            d = {d[6:0], r};
        end
    endtask

    task automatic get_ack(output logic ack);
        logic r;
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic start_c();
        cyc(Q); m_sda = 1'b1;
        cyc(Q); m_scl = 1'b1;
        cyc(Q); m_sda = 1'b0;
        cyc(Q); m_scl = 1'b0;
    endtask

    task automatic stop_c();
        cyc(Q); m_sda = 1'b0;
        cyc(Q); m_scl = 1'b1;
        cyc(Q); m_sda = 1'b1;
        cyc(Q);
        mbusy = 1'b0;
    endtask

    task automatic check_wq();
        chk_eq("wr_count", 64'(got_wq.size()), 64'(exp_wq.size()));
        for (int i = 0; i < exp_wq.size(); i++)
            chk_eq("wr_addr", 64'(qat(i)), 64'(exp_wq[i]));
        got_wq.delete();
        exp_wq.delete();
    endtask

    task automatic addr_phase(input logic [7:0] a);
        logic ack, match;
        send8(a);
        match = (a[7:1] == 7'h38);
        mbusy = match;
        get_ack(ack);
        chk_eq("addr_ack", 64'(ack), 64'(match));
    endtask

    task automatic do_write(input int n, input logic do_stop);
        logic ack;
        start_c();
        addr_phase(8'h70);
        for (int i = 0; i < n; i++) begin
            send8(wbuf[i]);
            if (i == 0) begin
                mptr = wbuf[0];
            end else begin
                if (mptr < 8) mregs[mptr[2:0]] = wbuf[i];
                exp_wq.push_back(mptr);
                mptr = mptr + 8'd1;
            end
            get_ack(ack);
            chk_eq("wr_ack", 64'(ack), 64'd1);
        end
        if (do_stop) begin
            stop_c();
            check_wq();
        end
    endtask

    task automatic do_read(input int n);
        logic [7:0] d, e;
        logic r;
        start_c();
        addr_phase(8'h71);
        for (int i = 0; i < n; i++) begin
            e = mdata(mptr);
            mptr = mptr + 8'd1;
            recv8(d);
            rbuf[i] = d;
            chk_eq("rd_data", 64'(d), 64'(e));
            if (i == n - 1) mbusy = 1'b0;
            bit_x((i == n - 1), r);
        end
        cyc(Q);
        chk_eq("sda_rel_nack", 64'(oen), 64'd1);
        stop_c();
        check_wq();
    endtask

    task automatic wrong_addr(input logic [7:0] a);
        logic ack;
        start_c();
        addr_phase(a);
        send8(8'h5A);
        get_ack(ack);
        chk_eq("wait_no_ack", 64'(ack), 64'd0);
        stop_c();
        check_wq();
    endtask

    initial begin
        int n, kind;
        logic [6:0] wa;
        rst = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        chk = 1'b0;
        glitch = 1'b0;
        status = 8'h00;
        mptr = 8'h00;
        mbusy = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        cyc(5);
        chk_eq("rst_oen", 64'(oen), 64'd1);
        chk_eq("rst_reg", reg_flat, 64'd0);
        chk_eq("rst_stb", 64'(wr_stb), 64'd0);
        chk_eq("rst_waddr", 64'(wr_addr), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        cyc(10);

        wbuf[0] = 8'h02; wbuf[1] = 8'hA5; wbuf[2] = 8'h5A;
        do_write(3, 1'b0);
        stop_c();
        chk_eq("t1_reg2", 64'(reg_flat[23:16]), 64'hA5);
        chk_eq("t1_reg3", 64'(reg_flat[31:24]), 64'h5A);
        chk_eq("t1_wa0", 64'(qat(0)), 64'h02);
        chk_eq("t1_wa1", 64'(qat(1)), 64'h03);
        check_wq();

        wbuf[0] = 8'h07; wbuf[1] = 8'h3C;
        do_write(2, 1'b1);
        wbuf[0] = 8'h07;
        do_write(1, 1'b0);
        status = 8'hC3;
        do_read(3);
        chk_eq("t2_rd0", 64'(rbuf[0]), 64'h3C);
        chk_eq("t2_rd1", 64'(rbuf[1]), 64'hC3);
        chk_eq("t2_rd2", 64'(rbuf[2]), 64'h00);

        wrong_addr(8'h72);

        wbuf[0] = 8'hFF; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
        do_write(3, 1'b0);
        stop_c();
        chk_eq("t4_reg0", 64'(reg_flat[7:0]), 64'h22);
        chk_eq("t4_wa0", 64'(qat(0)), 64'hFF);
        chk_eq("t4_wa1", 64'(qat(1)), 64'h00);
        check_wq();

        begin
            logic ack;
            start_c();
            addr_phase(8'h70);
            send8(8'h04);
            mptr = 8'h04;
            get_ack(ack);
            glitch = 1'b1;
            send8(8'h6B);
            mregs[4] = 8'h6B;
            exp_wq.push_back(8'h04);
            mptr = 8'h05;
            get_ack(ack);
            chk_eq("glitch_ack", 64'(ack), 64'd1);
            stop_c();
            chk_eq("glitch_reg4", 64'(reg_flat[39:32]), 64'h6B);
            check_wq();
        end

        begin
            logic ack;
            start_c();
            addr_phase(8'h70);
            send8(8'h00);
            mptr = 8'h00;
            get_ack(ack);
            send8(8'h11);
            mregs[0] = 8'h11;
            exp_wq.push_back(8'h00);
            mptr = 8'h01;
            cyc(Q);
            chk_eq("ack_low", 64'(oen), 64'd0);
            chk_eq("pre_rst_reg0", 64'(reg_flat[7:0]), 64'h11);
            check_wq();
            #2 rst = 1'b1;
            #1;
            chk_eq("mid_rst_oen", 64'(oen), 64'd1);
            chk_eq("mid_rst_reg", reg_flat, 64'd0);
            chk_eq("mid_rst_busy", 64'(busy), 64'd0);
            chk_eq("mid_rst_waddr", 64'(wr_addr), 64'd0);
            for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
            mptr = 8'h00;
            mbusy = 1'b0;
            m_sda = 1'b1;
            cyc(4);
            m_scl = 1'b1;
            cyc(4);
            rst = 1'b0;
            cyc(40);
            got_wq.delete();
            exp_wq.delete();
        end
        wbuf[0] = 8'h03; wbuf[1] = 8'h99;
        do_write(2, 1'b1);
        chk_eq("post_rst_reg3", 64'(reg_flat[31:24]), 64'h99);

        for (int t = 0; t < 14; t++) begin
            kind = int'($urandom_range(0, 4));
            if (kind <= 1) begin
                if ($urandom_range(0, 4) == 0)
                    wbuf[0] = 8'hFE + 8'($urandom_range(0, 1));
                else
                    wbuf[0] = 8'($urandom_range(0, 9));
                n = int'($urandom_range(1, 4));
                for (int i = 1; i < n; i++) wbuf[i] = 8'($urandom);
                do_write(n, 1'b1);
            end else if (kind <= 3) begin
                status = 8'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    wbuf[0] = 8'($urandom_range(0, 9));
                    do_write(1, 1'b0);
                end
                do_read(int'($urandom_range(1, 4)));
            end else begin
                wa = 7'($urandom_range(0, 127));
                if (wa == 7'h38) wa = 7'h39;
                wrong_addr({wa, 1'($urandom_range(0, 1))});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/twi_target.md
# twi_target

I2C (TWI) target that lets an external I2C master read and write a small byte-wide register bank inside the FPGA. It is the responder-side counterpart to the TWI master in the peripheral block. It oversamples SCL and SDA on the system clock, detects START and STOP conditions, and matches a fixed 7-bit address. It then handles pointer-addressed, auto-incrementing reads and writes, and drives SDA open-drain through an output-enable.

## Interface
Parameters:
- SLV_ADDR, 7'h38: 7-bit target address.
- FILT, 3: consecutive equal samples required before a filtered line changes; legal range 1-15.

Ports:
- CLK_I  in  1  system clock; all logic on rising edge. Must run at 16× SCL or faster.
- RST_I  in  1  reset; asynchronous, active-high.
- TWI_SCL_I  in  1  SCL pad input.
- TWI_SDA_I  in  1  SDA pad input.
- TWI_SDA_OEN  out  1  0 = pad drives SDA low; 1 = released. Reset value 1.
- STATUS_IN  in  8  read-only byte returned at pointer 8.
- REG_FLAT  out  64  register bank; byte i occupies [8i+7:8i]. Reset value 0.
- WR_STB  out  1  one-cycle pulse per data byte committed. Reset value 0.
- WR_ADDR  out  8  pointer of the last committed byte. Reset value 0.
- BUSY  out  1  1 from a START matching SLV_ADDR until STOP or NACK. Reset value 0.

## Operation
Input conditioning and bus events:
- Each pad input passes through a 2-FF synchronizer, then the FILT filter, producing scl_f and sda_f.
- Edge flags come from scl_f/sda_f delayed by one cycle.
- START: sda_f falls while scl_f is high. STOP: sda_f rises while scl_f is high.
- START and STOP are recognised in every state and take priority over bit processing.

Bit timing:
- Bits are MSB first.
- SDA is sampled on each scl_f rise.
- SDA is changed only on the cycle after an scl_f fall.
- A 3-bit counter tracks the bit position.

States:
- IDLE: SDA released.
  - START → ADDR.
- ADDR: shift 8 bits.
  - At the scl_f fall after the 8th rise: if byte[7:1]==SLV_ADDR → ADDR_ACK and drive SDA low.
  - Otherwise → WAIT.
- ADDR_ACK: at the following scl_f fall, release SDA.
  - R/W=1: load the TX shifter from data(ptr), ptr ← ptr+1, drive the MSB, → TX.
  - R/W=0: set first=1, → RX.
- RX: shift 8 bits. At the fall after the 8th rise, drive ACK and → RX_ACK.
  - If first=1: ptr ← byte, first ← 0.
  - If first=0 and ptr<8: REG_FLAT byte[ptr] ← byte.
  - If first=0 (any ptr): WR_STB=1 for one cycle, WR_ADDR ← ptr, ptr ← ptr+1.
- RX_ACK: at the next fall, release SDA → RX.
- TX: shift out on falls (7 remaining bits). At the fall after the 8th rise, release SDA → TX_ACK.
- TX_ACK: sample SDA on the rise.
  - 0 (ACK): at the next fall, load data(ptr), ptr ← ptr+1, drive the MSB, → TX.
  - 1 (NACK): → WAIT.
- WAIT: SDA released, BUSY=0. Only START or STOP are acted on.

Bus events in any state:
- STOP → IDLE, SDA released.
- Repeated START → ADDR; ptr is retained.

Data mapping:
- data(p) = REG_FLAT byte p for p<8, STATUS_IN for p=8, 8'h00 for p>8.
- Writes to p≥8 are ACKed and discarded. WR_STB still pulses for them.
- ptr is 8 bits and wraps 8'hFF→8'h00.
- STATUS_IN is captured at TX load time.

## Timing
- A pad transition reaches scl_f/sda_f 2+FILT cycles later.
- SDA is driven low or changed 1 CLK_I cycle after the internal scl_f-fall flag, giving roughly 3+FILT cycles after the pad edge.
- WR_STB asserts in the cycle ACK is driven for that byte. REG_FLAT updates in that same cycle.
- BUSY rises with ADDR_ACK entry. BUSY falls in the cycle STOP is detected or WAIT is entered.
- If START and an SCL edge are flagged in the same cycle, START wins.
- Reset mid-transfer: SDA released immediately (asynchronous). All registers and ptr clear to 0. State → IDLE.

## Test plan
- Write 0x70, 0x02, 0xA5, 0x5A, then STOP → REG_FLAT[23:16]=A5 and [31:24]=5A. Two WR_STB pulses with WR_ADDR 2, then 3. Every byte ACKed.
- Write 0x70, 0x07; repeated START; 0x71, read 3 bytes (ACK, ACK, NACK), STATUS_IN=C3 → bytes REG7, C3, 00 returned. SDA released after the NACK.
- Address 0x72 (wrong target) → no ACK on the 9th clock, SDA stays released, BUSY=0, no WR_STB.
- Pointer 0xFF, write 2 bytes → first byte discarded, second goes to REG0. WR_ADDR sequence FF, 00.
- 1-cycle glitch on SCL with FILT=3 → no bit shifted, state unchanged.
- Assert RST_I while SDA is held low for ACK → TWI_SDA_OEN=1 within the reset, REG_FLAT=0. The next transaction succeeds.
